// File: rtl/seg_ctrl_pkg.sv
// Shared definitions for the seven-segment message display: character codes,
// anode patterns, scan-state enumeration and the blank segment pattern.
package seg_ctrl_pkg;

  localparam int unsigned CODE_W = 4;
  localparam int unsigned SEG_W  = 7;
  localparam int unsigned AN_W   = 4;

  typedef logic [CODE_W-1:0] code_t;
  typedef logic [SEG_W-1:0]  seg_t;
  typedef logic [AN_W-1:0]   an_t;

  // Character codes, in order of the message "1oProject2022-23"
  localparam code_t CH_1    = 4'd0;
  localparam code_t CH_O_A  = 4'd1;
  localparam code_t CH_P    = 4'd2;
  localparam code_t CH_R    = 4'd3;
  localparam code_t CH_O_B  = 4'd4;
  localparam code_t CH_J    = 4'd5;
  localparam code_t CH_E    = 4'd6;
  localparam code_t CH_C    = 4'd7;
  localparam code_t CH_T    = 4'd8;
  localparam code_t CH_2_A  = 4'd9;
  localparam code_t CH_0    = 4'd10;
  localparam code_t CH_2_B  = 4'd11;
  localparam code_t CH_2_C  = 4'd12;
  localparam code_t CH_DASH = 4'd13;
  localparam code_t CH_2_D  = 4'd14;
  localparam code_t CH_3    = 4'd15;

  // Active-low anode patterns; an[3] is the leftmost digit
  localparam an_t AN_DIG3 = 4'b0111;
  localparam an_t AN_DIG2 = 4'b1011;
  localparam an_t AN_DIG1 = 4'b1101;
  localparam an_t AN_DIG0 = 4'b1110;
  localparam an_t AN_OFF  = 4'b1111;

  // All segments dark (active-low)
  localparam seg_t SEG_OFF = 7'b1111111;

  typedef enum logic [1:0] {DIG3, DIG2, DIG1, DIG0} scan_state_t;

  // Anode pattern lighting the digit of a scan state
  function automatic an_t state_anode(input scan_state_t s);
    case (s)
      DIG3:    return AN_DIG3;
      DIG2:    return AN_DIG2;
      DIG1:    return AN_DIG1;
      DIG0:    return AN_DIG0;
      default: return AN_OFF;
    endcase
  endfunction

  // Character offset from head for the digit of a scan state
  function automatic code_t digit_offset(input scan_state_t s);
    case (s)
      DIG3:    return 4'd0;
      DIG2:    return 4'd1;
      DIG1:    return 4'd2;
      DIG0:    return 4'd3;
      default: return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/LEDdecoder.sv
// Combinational character-code to active-low segment decoder (order ca..cg).
module LEDdecoder
  import seg_ctrl_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] LED
);

  // Glyph lookup for each message character
  always_comb begin
    LED = SEG_OFF;
    case (code)
      CH_1:    LED = 7'b1001111;
      CH_O_A:  LED = 7'b1100010;
      CH_P:    LED = 7'b0011000;
      CH_R:    LED = 7'b1111010;
      CH_O_B:  LED = 7'b1100010;
      CH_J:    LED = 7'b1000111;
      CH_E:    LED = 7'b0010000;
      CH_C:    LED = 7'b1110010;
      CH_T:    LED = 7'b1110000;
      CH_2_A:  LED = 7'b0010010;
      CH_0:    LED = 7'b0000001;
      CH_2_B:  LED = 7'b0010010;
      CH_2_C:  LED = 7'b0010010;
      CH_DASH: LED = 7'b1111110;
      CH_2_D:  LED = 7'b0010010;
      CH_3:    LED = 7'b0000110;
      default: LED = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/msg_scroll_ctrl.sv
// Scrolling four-digit message controller: multiplexes the anodes, decodes
// the visible window of the 16-character message and scrolls it.
// Build option: define MSG_SCROLL_EN to enable scrolling, pause and step;
// without it the display is a static "1oPr" and head/wrap stay 0.
module msg_scroll_ctrl
  import seg_ctrl_pkg::*;
#(
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned SCROLL_DIV   = 50000000,
  parameter int unsigned BLANK_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pause,
  input  logic       step,
  output logic [3:0] an,
  output logic [6:0] LED,
  output logic [3:0] head,
  output logic       wrap
);

  localparam int unsigned RCW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [RCW-1:0] R_LAST  = RCW'(REFRESH_DIV - 1);
  localparam logic [RCW-1:0] R_BLANK = RCW'(BLANK_CYCLES);

  logic [RCW-1:0] rcnt;
  logic [RCW-1:0] rcnt_nxt;
  logic           rwrap_c;

  scan_state_t state;
  scan_state_t state_nxt;
  an_t         slot_an;
  an_t         slot_an_nxt;
  an_t         an_nxt;
  seg_t        led_nxt;
  code_t       code_c;
  seg_t        seg_c;

  assign rwrap_c  = (rcnt == R_LAST);
  assign rcnt_nxt = rwrap_c ? '0 : rcnt + RCW'(1);

  // Character for the digit being loaded; head is sampled once per slot
  assign code_c = head + digit_offset(state);

  LEDdecoder u_dec (
    .code (code_c),
    .LED  (seg_c)
  );

  // Refresh counter and registered display outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rcnt    <= '0;
      slot_an <= AN_OFF;
      an      <= AN_OFF;
      LED     <= SEG_OFF;
    end else begin
      rcnt    <= rcnt_nxt;
      slot_an <= slot_an_nxt;
      an      <= an_nxt;
      LED     <= led_nxt;
    end
  end

  // Scan state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= DIG3;
    else        state <= state_nxt;
  end

  // Scan next state; the wrap edge latches the digit and glyph for the next slot
  always_comb begin
    state_nxt   = state;
    slot_an_nxt = slot_an;
    led_nxt     = LED;
    if (rwrap_c) begin
      case (state)
        DIG3:    state_nxt = DIG2;
        DIG2:    state_nxt = DIG1;
        DIG1:    state_nxt = DIG0;
        DIG0:    state_nxt = DIG3;
        default: state_nxt = DIG3;
      endcase
      slot_an_nxt = state_anode(state);
      led_nxt     = seg_c;
    end
    an_nxt = (rcnt_nxt < R_BLANK) ? AN_OFF : slot_an_nxt;
  end

`ifdef MSG_SCROLL_EN
  localparam int unsigned SCW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam logic [SCW-1:0] S_LAST = SCW'(SCROLL_DIV - 1);

  logic [SCW-1:0] scnt;
  logic           swrap_c;
  logic           adv_c;

  // Scroll wrap only while running, step only while paused: never both
  assign swrap_c = !pause && (scnt == S_LAST);
  assign adv_c   = swrap_c || (pause && step);

  // Scroll counter, head and 15->0 wrap pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scnt <= '0;
      head <= '0;
      wrap <= 1'b0;
    end else begin
      if (!pause) scnt <= swrap_c ? '0 : scnt + SCW'(1);
      head <= head + CODE_W'(adv_c);
      wrap <= adv_c && (head == 4'hF);
    end
  end
`else
  logic unused_inputs;
  assign unused_inputs = ^{pause, step};

  // Static build: head and wrap held at zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head <= '0;
      wrap <= 1'b0;
    end else begin
      head <= '0;
      wrap <= 1'b0;
    end
  end
`endif

endmodule
